// File: rtl/cpu_bus_sequencer.sv
// Command-driven sequencer for the 8-bit CPU datapath: turns WRITE/READ/ALU
// commands into register-file and ALU strobes and returns one response each.
module cpu_bus_sequencer #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 2,
  parameter int OP_W     = 4,
  parameter int RD_WAIT  = 1,
  localparam int IDX_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                i_pld_clk,
  input  logic                i_pld_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [IDX_W-1:0]    i_cmd_reg,
  input  logic [DATA_W-1:0]   i_cmd_data_a,
  input  logic [DATA_W-1:0]   i_cmd_data_b,
  input  logic [OP_W-1:0]     i_cmd_alu_op,
  input  logic                i_cmd_cin,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  output logic [NUM_REGS-1:0] o_reg_wrtn,
  output logic [NUM_REGS-1:0] o_reg_rdn,
  output logic [OP_W-1:0]     o_alu_opcode,
  output logic                o_alu_cin,
  output logic                o_alu_sel,
  output logic                o_alu_flag_sel,
  output logic [DATA_W-1:0]   o_bus_data,
  output logic                o_bus_oe,
  input  logic [DATA_W-1:0]   i_bus_data,
  output logic                o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RD, S_REL, S_EXEC1, S_EXEC2, S_RSP
  } state_t;

  localparam logic [NUM_REGS-1:0] ALL_ONE = {NUM_REGS{1'b1}};
  localparam logic [2:0]          RD_LAST = 3'(RD_WAIT);

  function automatic logic [NUM_REGS-1:0] f_strobe(input logic [IDX_W-1:0] idx);
    f_strobe = ~({{(NUM_REGS-1){1'b0}}, 1'b1} << idx);
  endfunction

  state_t              r_state;
  logic                r_is_alu;
  logic                r_phase;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_data_b;
  logic [OP_W-1:0]     r_op_l;
  logic                r_cin_l;
  logic [2:0]          r_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [NUM_REGS-1:0] r_wrtn;
  logic [NUM_REGS-1:0] r_rdn;
  logic [OP_W-1:0]     r_alu_opcode;
  logic                r_alu_cin;
  logic                r_alu_sel;
  logic [DATA_W-1:0]   r_bus_data;
  logic                r_bus_oe;

  logic w_cmd_ready;
  logic w_accept;
  logic w_err;

  // The register index is only meaningful for WRITE and READ.
  assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
  assign w_accept    = i_cmd_valid && w_cmd_ready;
  assign w_err       = (i_cmd_op == 2'b11) ||
                       ((i_cmd_op != 2'b10) && (32'(i_cmd_reg) >= NUM_REGS));

  // Sequencer state and all registered strobe / response outputs.
  always_ff @(posedge i_pld_clk) begin
    if (i_pld_rst) begin
      r_state      <= S_IDLE;
      r_is_alu     <= 1'b0;
      r_phase      <= 1'b0;
      r_idx        <= {IDX_W{1'b0}};
      r_data_b     <= {DATA_W{1'b0}};
      r_op_l       <= {OP_W{1'b0}};
      r_cin_l      <= 1'b0;
      r_cnt        <= 3'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= {DATA_W{1'b0}};
      r_rsp_err    <= 1'b0;
      r_wrtn       <= ALL_ONE;
      r_rdn        <= ALL_ONE;
      r_alu_opcode <= {OP_W{1'b0}};
      r_alu_cin    <= 1'b0;
      r_alu_sel    <= 1'b0;
      r_bus_data   <= {DATA_W{1'b0}};
      r_bus_oe     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx    <= i_cmd_reg;
            r_data_b <= i_cmd_data_b;
            r_op_l   <= i_cmd_alu_op;
            r_cin_l  <= i_cmd_cin;
            r_phase  <= 1'b0;
            r_cnt    <= 3'd0;
            if (w_err) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= {DATA_W{1'b0}};
            end else if (i_cmd_op == 2'b01) begin
              r_state <= S_RD;
              r_rdn   <= f_strobe(i_cmd_reg);
            end else begin
              // ALU commands start as a WRITE of operand A to register 0.
              r_state    <= S_SETUP;
              r_is_alu   <= (i_cmd_op == 2'b10);
              r_bus_oe   <= 1'b1;
              r_bus_data <= i_cmd_data_a;
              if (i_cmd_op == 2'b10) begin
                r_idx <= {IDX_W{1'b0}};
              end
            end
          end
        end
        S_SETUP: begin
          r_wrtn  <= f_strobe(r_idx);
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_wrtn  <= ALL_ONE;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_is_alu && !r_phase) begin
            r_phase    <= 1'b1;
            r_idx      <= IDX_W'(1'b1);
            r_bus_data <= r_data_b;
            r_state    <= S_SETUP;
          end else if (r_is_alu) begin
            r_bus_oe       <= 1'b0;
            r_alu_sel      <= 1'b1;
            r_alu_opcode   <= r_op_l;
            r_alu_cin      <= r_cin_l;
            r_state        <= S_EXEC1;
          end else begin
            r_bus_oe    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= {DATA_W{1'b0}};
            r_state     <= S_RSP;
          end
        end
        S_RD: begin
          if (r_cnt == RD_LAST) begin
            r_rsp_data <= i_bus_data;
            r_rdn      <= ALL_ONE;
            r_state    <= S_REL;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_REL: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_state     <= S_RSP;
        end
        S_EXEC1: r_state <= S_EXEC2;
        S_EXEC2: begin
          r_rsp_data  <= i_bus_data;
          r_alu_sel   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= {DATA_W{1'b0}};
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready    = w_cmd_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_err      = r_rsp_err;
  assign o_reg_wrtn     = r_wrtn;
  assign o_reg_rdn      = r_rdn;
  assign o_alu_opcode   = r_alu_opcode;
  assign o_alu_cin      = r_alu_cin;
  assign o_alu_sel      = r_alu_sel;
  assign o_alu_flag_sel = r_alu_sel;
  assign o_bus_data     = r_bus_data;
  assign o_bus_oe       = r_bus_oe;
  assign o_busy         = (r_state != S_IDLE);

endmodule
